toy_bpu_mem_sched: RTL and testbench
====================================

Name: toy_bpu_mem_sched

Overview:
- Scheduler in front of one single-port BPU SRAM bank, e.g. the BTB way and PLRU node arrays, which share one address per cycle.
- Shares the port between prediction reads (fetch side, high priority) and update writes (commit side, buffered in a small write queue).
- After reset, runs an init sweep that zeroes every entry before any traffic is accepted.
- A starvation counter guarantees queued writes make progress under continuous read pressure.

Parameters:
- ADDR_WIDTH, 9, SRAM index width (matches BTB_INDEX_WIDTH).
- DATA_WIDTH, 64, SRAM word width.
- WMASK_WIDTH, 4, write-enable lanes (matches BTB_WAY_NUM).
- WQ_DEPTH, 4, write-queue entries; power of 2, at least 2.
- STARVE_MAX, 8, consecutive read-won cycles allowed while the write queue is non-empty.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- init_done  out  1  high once the init sweep completes
- pred_req_vld  in  1  prediction read request
- pred_req_rdy  out  1  read accepted this cycle
- pred_req_addr  in  ADDR_WIDTH  read index
- pred_rsp_vld  out  1  read data valid
- pred_rsp_rdata  out  DATA_WIDTH  read data
- pred_rsp_stale  out  1  a queued, unretired write targets the same index
- upd_req_vld  in  1  update write request
- upd_req_rdy  out  1  write queue can accept
- upd_req_addr  in  ADDR_WIDTH  write index
- upd_req_wdata  in  DATA_WIDTH  write data
- upd_req_wmask  in  WMASK_WIDTH  lane enables; all-zero is accepted and discarded
- mem_req_vld  out  1  SRAM enable
- mem_req_wren  out  WMASK_WIDTH  SRAM lane write enables; zero means read
- mem_req_addr  out  ADDR_WIDTH  SRAM index
- mem_req_wdata  out  DATA_WIDTH  SRAM write data
- mem_ack_rdata  in  DATA_WIDTH  SRAM read data, one cycle after the read enable

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset state: state=INIT, init_cnt=0, write queue empty, starve_cnt=0, init_done=0, pred_req_rdy=0, upd_req_rdy=0, pred_rsp_vld=0, pred_rsp_stale=0, pred_rsp_rdata=0.
- INIT state:
  - Each cycle drives mem_req_vld=1, mem_req_wren=all ones, mem_req_addr=init_cnt, mem_req_wdata=0, then init_cnt++.
  - After writing address 2^ADDR_WIDTH-1, moves to RUN; init_done=1 from the next cycle onward.
  - Sweep length is exactly 2^ADDR_WIDTH cycles.
- RUN state, one SRAM access per cycle:
  - force_wr = (queue non-empty) && (starve_cnt == STARVE_MAX).
  - pred_req_rdy = !force_wr. A read issues when pred_req_vld && pred_req_rdy: mem_req_vld=1, mem_req_wren=0, mem_req_addr=pred_req_addr.
  - Otherwise, if the queue is non-empty, the head issues as a write (mem_req_wren=head wmask, addr/wdata from head) and is popped.
  - Otherwise mem_req_vld=0, and wren/addr/wdata are driven 0.
- Starvation counter:
  - starve_cnt increments on a cycle where a read issues and the queue is non-empty.
  - It clears on any write issue, or whenever the queue is empty.
  - It saturates at STARVE_MAX.
- Read response:
  - pred_rsp_vld is asserted exactly one cycle after a read issues; pred_rsp_rdata = mem_ack_rdata in that cycle.
  - pred_rsp_stale is registered at issue time: 1 if any valid queue entry's address equals pred_req_addr. The entry popped in the same cycle is excluded, because no pop happens on a read cycle.
  - pred_rsp_rdata is don't-care when pred_rsp_vld=0 (it holds its last value).
- Write queue:
  - FIFO with wrap-around read/write pointers plus a count.
  - upd_req_rdy = (state==RUN) && (count < WQ_DEPTH). It depends only on count, so a full queue does not accept in the same cycle it pops.
  - Push on upd_req_vld && upd_req_rdy && (wmask != 0). An all-zero mask completes the handshake without pushing.
  - Simultaneous push and pop keeps count unchanged.
  - Same-address writes are not merged; they retire in order.
- Invariants: the read port and write port never issue in the same cycle. pred_req_rdy=0 in INIT.
- Reset mid-operation: the queue and any in-flight response are discarded, pred_rsp_vld=0 next cycle, and the INIT sweep restarts from 0.

Decomposition:
- Shared package (toy_pack): BPU_MEM_WQ_DEPTH, BPU_MEM_STARVE_MAX, and typedef bpu_mem_wq_entry_pkg {addr, wdata, wmask}.
- Sub-module toy_bpu_mem_wq: write-queue FIFO with per-entry address-match output (CAM compare against pred_req_addr). Scheduler FSM, starvation counter and init counter stay in toy_bpu_mem_sched.

Test Plan:
- Reset, then idle: init sweep with ADDR_WIDTH=4 -> exactly 16 consecutive writes, addr 0..15, wdata 0, wren 4'hF; init_done=1 on cycle 17; a read of addr 5 returns 0 one cycle after issue.
- Write then read: upd addr=3, wdata=0xAB, wmask=4'hF while no reads -> write issues the next cycle; a later read of 3 -> pred_rsp_rdata=0xAB, pred_rsp_stale=0.
- Starvation: queue holds one write; pred_req_vld held high -> 8 reads issue, the 9th cycle has pred_req_rdy=0 and the write issues; cycle 10 the read resumes.
- Stale hazard: push addr=7 while reads saturate the port; read addr=7 -> pred_rsp_stale=1 with old data; after the forced write retires, read 7 -> stale=0, new data.
- Full queue: push 4 writes during continuous reads -> upd_req_rdy=0; same-cycle forced pop -> rdy stays 0 that cycle, returns to 1 the next; entries retire in order with no loss.
- Reset mid-run: assert rst with 3 queued writes and a read in flight -> pred_rsp_vld=0 next cycle, no queued write ever reaches the SRAM, init sweep restarts at addr 0.

Source files
------------

// File: rtl/toy_pack.sv
// Shared constants and types for the BPU SRAM port scheduler.
package toy_pack;

  localparam int BPU_MEM_ADDR_WIDTH  = 9;
  localparam int BPU_MEM_DATA_WIDTH  = 64;
  localparam int BPU_MEM_WMASK_WIDTH = 4;
  localparam int BPU_MEM_WQ_DEPTH    = 4;
  localparam int BPU_MEM_STARVE_MAX  = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpu_mem_state_e;

  // Write-queue entry layout for the default bank geometry.
  typedef struct packed {
    logic [BPU_MEM_ADDR_WIDTH-1:0]  addr;
    logic [BPU_MEM_DATA_WIDTH-1:0]  wdata;
    logic [BPU_MEM_WMASK_WIDTH-1:0] wmask;
  } bpu_mem_wq_entry_pkg;

endpackage

// File: rtl/toy_bpu_mem_wq.sv
// Update write queue: circular FIFO with a per-entry address compare against
// the current prediction read index.
module toy_bpu_mem_wq
  import toy_pack::*;
#(
  parameter int ADDR_WIDTH  = BPU_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = BPU_MEM_DATA_WIDTH,
  parameter int WMASK_WIDTH = BPU_MEM_WMASK_WIDTH,
  parameter int DEPTH       = BPU_MEM_WQ_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [ADDR_WIDTH-1:0]          push_addr,
  input  logic [DATA_WIDTH-1:0]          push_wdata,
  input  logic [WMASK_WIDTH-1:0]         push_wmask,
  input  logic                           pop,
  output logic [ADDR_WIDTH-1:0]          head_addr,
  output logic [DATA_WIDTH-1:0]          head_wdata,
  output logic [WMASK_WIDTH-1:0]         head_wmask,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  input  logic [ADDR_WIDTH-1:0]          match_addr,
  output logic [DEPTH-1:0]               match_vec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [WMASK_WIDTH-1:0] wmask;
  } entry_t;

  entry_t             mem_reg [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= {push_addr, push_wdata, push_wmask};
  end

  assign head_addr  = mem_reg[rd_ptr_reg].addr;
  assign head_wdata = mem_reg[rd_ptr_reg].wdata;
  assign head_wmask = mem_reg[rd_ptr_reg].wmask;
  assign count      = count_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offset;
      assign offset        = PTR_W'(gi) - rd_ptr_reg;
      assign match_vec[gi] = (CNT_W'(offset) < count_reg) &&
                             (mem_reg[gi].addr == match_addr);
    end
  endgenerate

endmodule

// File: rtl/toy_bpu_mem_sched.sv
// Single-port BPU SRAM scheduler: init sweep, priority reads, queued writes
// with a starvation bound on read priority.
module toy_bpu_mem_sched
  import toy_pack::*;
#(
  parameter int ADDR_WIDTH  = BPU_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = BPU_MEM_DATA_WIDTH,
  parameter int WMASK_WIDTH = BPU_MEM_WMASK_WIDTH,
  parameter int WQ_DEPTH    = BPU_MEM_WQ_DEPTH,
  parameter int STARVE_MAX  = BPU_MEM_STARVE_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic                   pred_req_vld,
  output logic                   pred_req_rdy,
  input  logic [ADDR_WIDTH-1:0]  pred_req_addr,
  output logic                   pred_rsp_vld,
  output logic [DATA_WIDTH-1:0]  pred_rsp_rdata,
  output logic                   pred_rsp_stale,
  input  logic                   upd_req_vld,
  output logic                   upd_req_rdy,
  input  logic [ADDR_WIDTH-1:0]  upd_req_addr,
  input  logic [DATA_WIDTH-1:0]  upd_req_wdata,
  input  logic [WMASK_WIDTH-1:0] upd_req_wmask,
  output logic                   mem_req_vld,
  output logic [WMASK_WIDTH-1:0] mem_req_wren,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [DATA_WIDTH-1:0]  mem_req_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_ack_rdata
);

  localparam int CNT_W = $clog2(WQ_DEPTH+1);
  localparam int SW    = $clog2(STARVE_MAX+1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(WQ_DEPTH);
  localparam logic [SW-1:0]    STARVE_C = SW'(STARVE_MAX);

  bpu_mem_state_e        state_reg, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt_reg, init_cnt_next;
  logic [SW-1:0]         starve_cnt_reg, starve_cnt_next;
  logic                  rsp_vld_reg;
  logic                  rsp_stale_reg;
  logic [DATA_WIDTH-1:0] rsp_hold_reg;

  logic                   read_issue, write_issue, force_wr, wq_push, wq_empty;
  logic [CNT_W-1:0]       wq_count;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [DATA_WIDTH-1:0]  head_wdata;
  logic [WMASK_WIDTH-1:0] head_wmask;
  logic [WQ_DEPTH-1:0]    match_vec;

  toy_bpu_mem_wq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WMASK_WIDTH(WMASK_WIDTH),
    .DEPTH      (WQ_DEPTH)
  ) u_wq (
    .clk        (clk),
    .rst        (rst),
    .push       (wq_push),
    .push_addr  (upd_req_addr),
    .push_wdata (upd_req_wdata),
    .push_wmask (upd_req_wmask),
    .pop        (write_issue),
    .head_addr  (head_addr),
    .head_wdata (head_wdata),
    .head_wmask (head_wmask),
    .count      (wq_count),
    .match_addr (pred_req_addr),
    .match_vec  (match_vec)
  );

  assign wq_empty = (wq_count == '0);

  always_comb begin
    state_next      = state_reg;
    init_cnt_next   = init_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    force_wr        = 1'b0;
    read_issue      = 1'b0;
    write_issue     = 1'b0;
    wq_push         = 1'b0;
    pred_req_rdy    = 1'b0;
    upd_req_rdy     = 1'b0;
    mem_req_vld     = 1'b0;
    mem_req_wren    = '0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    // Nothing reaches the SRAM or the queue while reset is asserted.
    if (!rst) begin
      case (state_reg)
        ST_INIT: begin
          mem_req_vld   = 1'b1;
          mem_req_wren  = '1;
          mem_req_addr  = init_cnt_reg;
          init_cnt_next = init_cnt_reg + ADDR_WIDTH'(1);
          if (&init_cnt_reg) state_next = ST_RUN;
        end
        ST_RUN: begin
          force_wr     = !wq_empty && (starve_cnt_reg == STARVE_C);
          pred_req_rdy = !force_wr;
          upd_req_rdy  = (wq_count < DEPTH_C);
          wq_push      = upd_req_vld && upd_req_rdy && (upd_req_wmask != '0);
          if (pred_req_vld && pred_req_rdy) begin
            read_issue   = 1'b1;
            mem_req_vld  = 1'b1;
            mem_req_addr = pred_req_addr;
          end else if (!wq_empty) begin
            write_issue   = 1'b1;
            mem_req_vld   = 1'b1;
            mem_req_wren  = head_wmask;
            mem_req_addr  = head_addr;
            mem_req_wdata = head_wdata;
          end
          if (write_issue || wq_empty) begin
            starve_cnt_next = '0;
          end else if (read_issue && (starve_cnt_reg < STARVE_C)) begin
            starve_cnt_next = starve_cnt_reg + SW'(1);
          end
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_INIT;
      init_cnt_reg   <= '0;
      starve_cnt_reg <= '0;
      rsp_vld_reg    <= 1'b0;
      rsp_stale_reg  <= 1'b0;
      rsp_hold_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      init_cnt_reg   <= init_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      rsp_vld_reg    <= read_issue;
      rsp_stale_reg  <= read_issue && (|match_vec);
      if (rsp_vld_reg) rsp_hold_reg <= mem_ack_rdata;
    end
  end

  assign init_done      = (state_reg == ST_RUN);
  assign pred_rsp_vld   = rsp_vld_reg;
  assign pred_rsp_stale = rsp_stale_reg;
  assign pred_rsp_rdata = rsp_vld_reg ? mem_ack_rdata : rsp_hold_reg;

endmodule

// File: tb/tb_toy_bpu_mem_sched.sv
// Randomized bench for toy_bpu_mem_sched against a transaction-level model
// of the bank, the pending-write list and the read-priority rules.
module tb_toy_bpu_mem_sched;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int MW    = 4;
  localparam int LW    = DW / MW;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
  localparam int NENT  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done;
  logic          pred_req_vld = 1'b0;
  logic          pred_req_rdy;
  logic [AW-1:0] pred_req_addr = '0;
  logic          pred_rsp_vld;
  logic [DW-1:0] pred_rsp_rdata;
  logic          pred_rsp_stale;
  logic          upd_req_vld = 1'b0;
  logic          upd_req_rdy;
  logic [AW-1:0] upd_req_addr = '0;
  logic [DW-1:0] upd_req_wdata = '0;
  logic [MW-1:0] upd_req_wmask = '0;
  logic          mem_req_vld;
  logic [MW-1:0] mem_req_wren;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [DW-1:0] mem_ack_rdata = '0;

  always #5 clk = ~clk;

  toy_bpu_mem_sched #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW),
    .WQ_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .pred_req_vld(pred_req_vld), .pred_req_rdy(pred_req_rdy),
    .pred_req_addr(pred_req_addr), .pred_rsp_vld(pred_rsp_vld),
    .pred_rsp_rdata(pred_rsp_rdata), .pred_rsp_stale(pred_rsp_stale),
    .upd_req_vld(upd_req_vld), .upd_req_rdy(upd_req_rdy),
    .upd_req_addr(upd_req_addr), .upd_req_wdata(upd_req_wdata),
    .upd_req_wmask(upd_req_wmask), .mem_req_vld(mem_req_vld),
    .mem_req_wren(mem_req_wren), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_ack_rdata(mem_ack_rdata)
  );

  // Behavioural single-port SRAM attached to the DUT.
  logic [DW-1:0] sram [NENT];
  always @(posedge clk) begin
    if (mem_req_vld) begin
      if (mem_req_wren == '0) mem_ack_rdata <= sram[mem_req_addr];
      else begin
        for (int l = 0; l < MW; l++)
          if (mem_req_wren[l]) sram[mem_req_addr][l*LW +: LW] <= mem_req_wdata[l*LW +: LW];
      end
    end
  end

  typedef struct {
    int            addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } wr_t;

  wr_t           m_wq[$];
  logic [DW-1:0] ref_mem [NENT];
  bit            m_init;
  int            m_idx;
  int            m_starve;
  bit            m_rsp_pend;
  bit            m_rsp_stale;
  logic [DW-1:0] m_rsp_data;
  logic [DW-1:0] m_hold;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < MW; l++) if (m[l]) r[l*LW +: LW] = nw[l*LW +: LW];
    return r;
  endfunction

  task automatic model_reset();
    m_init = 1; m_idx = 0; m_wq.delete(); m_starve = 0;
    m_rsp_pend = 0; m_rsp_stale = 0; m_hold = '0;
  endtask

  task automatic check_and_step();
    int  sz;
    bit  frc, rd, wr, stl;
    wr_t h;
    check("rsp_vld", {63'd0, pred_rsp_vld}, {63'd0, m_rsp_pend});
    if (m_rsp_pend) begin
      check("rsp_rdata", pred_rsp_rdata, m_rsp_data);
      check("rsp_stale", {63'd0, pred_rsp_stale}, {63'd0, m_rsp_stale});
      m_hold = m_rsp_data;
    end else begin
      check("rsp_hold", pred_rsp_rdata, m_hold);
    end
    if (m_init) begin
      check("init_done0", {63'd0, init_done}, 64'd0);
      check("init_prdy", {63'd0, pred_req_rdy}, 64'd0);
      check("init_urdy", {63'd0, upd_req_rdy}, 64'd0);
      check("init_stale", {63'd0, pred_rsp_stale}, 64'd0);
      check("init_vld", {63'd0, mem_req_vld}, 64'd1);
      check("init_wren", {60'd0, mem_req_wren}, 64'hF);
      check("init_addr", {60'd0, mem_req_addr}, 64'(m_idx));
      check("init_wdata", mem_req_wdata, 64'd0);
      ref_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == NENT) m_init = 0;
      m_rsp_pend = 0;
      return;
    end
    sz  = m_wq.size();
    frc = (sz > 0) && (m_starve >= SMAX);
    rd  = pred_req_vld && !frc;
    wr  = 0;
    stl = 0;
    check("init_done1", {63'd0, init_done}, 64'd1);
    check("pred_rdy", {63'd0, pred_req_rdy}, {63'd0, !frc});
    check("upd_rdy", {63'd0, upd_req_rdy}, {63'd0, sz < DEPTH});
    if (rd) begin
      foreach (m_wq[i]) if (m_wq[i].addr == int'(pred_req_addr)) stl = 1;
      m_rsp_data = ref_mem[pred_req_addr];
      check("rd_vld", {63'd0, mem_req_vld}, 64'd1);
      check("rd_wren", {60'd0, mem_req_wren}, 64'd0);
      check("rd_addr", {60'd0, mem_req_addr}, {60'd0, pred_req_addr});
      check("rd_wdata", mem_req_wdata, 64'd0);
    end else if (sz > 0) begin
      h  = m_wq.pop_front();
      wr = 1;
      check("wr_vld", {63'd0, mem_req_vld}, 64'd1);
      check("wr_wren", {60'd0, mem_req_wren}, {60'd0, h.wmask});
      check("wr_addr", {60'd0, mem_req_addr}, 64'(h.addr));
      check("wr_wdata", mem_req_wdata, h.wdata);
      ref_mem[h.addr] = merge(ref_mem[h.addr], h.wdata, h.wmask);
    end else begin
      check("idle_vld", {63'd0, mem_req_vld}, 64'd0);
      check("idle_bus", {mem_req_wdata[DW-1:8], mem_req_addr, mem_req_wren}, 64'd0);
    end
    if (upd_req_vld && sz < DEPTH && upd_req_wmask != '0)
      m_wq.push_back('{addr: int'(upd_req_addr), wdata: upd_req_wdata, wmask: upd_req_wmask});
    if (wr || sz == 0) m_starve = 0;
    else if (rd && m_starve < SMAX) m_starve++;
    m_rsp_pend  = rd;
    m_rsp_stale = stl;
  endtask

  task automatic cycle(input bit r, input bit pv, input int pa, input bit uv, input int ua,
                       input logic [DW-1:0] ud, input logic [MW-1:0] um);
    @(posedge clk);
    #1;
    cyc++;
    rst = r; pred_req_vld = pv; pred_req_addr = pa[AW-1:0];
    upd_req_vld = uv; upd_req_addr = ua[AW-1:0]; upd_req_wdata = ud; upd_req_wmask = um;
    #3;
    if (r) begin
      check("rst_mem_vld", {63'd0, mem_req_vld}, 64'd0);
      check("rst_urdy", {63'd0, upd_req_rdy}, 64'd0);
      model_reset();
    end else begin
      check_and_step();
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [MW-1:0] rmask();
    logic [MW-1:0] m;
    m = MW'($urandom);
    if ($urandom_range(0, 7) == 0) m = '0;
    return m;
  endfunction

  initial begin
    int pv_pct;
    model_reset();
    cycle(1, 0, 0, 0, 0, '0, '0);
    cycle(1, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < NENT; i++)
      cycle(0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom, rnd64(), 4'hF);
    cycle(0, 1, 5, 0, 0, '0, '0);
    cycle(0, 0, 0, 0, 0, '0, '0);
    cycle(0, 0, 0, 1, 3, 64'hAB, 4'hF);
    cycle(0, 0, 0, 0, 0, '0, '0);
    cycle(0, 0, 0, 0, 0, '0, '0);
    cycle(0, 1, 3, 0, 0, '0, '0);
    cycle(0, 0, 0, 0, 0, '0, '0);
    cycle(0, 1, 1, 1, 9, rnd64(), 4'h5);
    for (int i = 0; i < 11; i++) cycle(0, 1, $urandom, 0, 0, '0, '0);
    cycle(0, 1, 2, 1, 7, 64'h1234_5678_9ABC_DEF0, 4'hF);
    for (int i = 0; i < 12; i++) cycle(0, 1, 7, 0, 0, '0, '0);
    for (int i = 0; i < 20; i++) cycle(0, 1, $urandom, 1, $urandom, rnd64(), 4'hF);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, $urandom, 1, $urandom, rnd64(), 4'hF);
    cycle(0, 1, 4, 0, 0, '0, '0);
    cycle(1, 1, 4, 1, 2, rnd64(), 4'hF);
    for (int i = 0; i < NENT + 4; i++) cycle(0, 1, $urandom, 1, $urandom, rnd64(), 4'hF);
    pv_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) pv_pct = $urandom_range(0, 100);
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 99) < pv_pct), $urandom,
            $urandom_range(0, 1), $urandom, rnd64(), rmask());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
